// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencing controller for the keypad calculator.
// Builds two unsigned decimal operands from decoded key strobes, latches the
// operator (add/subtract), computes a signed result on "=" and holds the value
// shown on the display. All outputs are registered (1-cycle latency per key).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   key_valid         one-cycle key strobe; decoded fields valid only while high
//   is_number/is_op/is_eq, num_val, op_val   decoded key fields
//   disp_val/disp_neg displayed magnitude and sign
//   err               overflow error latched
//   result_valid      one-cycle pulse when a result is committed
//   state_o           current FSM state (debug / display blanking)
module calc_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned VAL_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             is_number,
  input  logic             is_op,
  input  logic             is_eq,
  input  logic [3:0]       num_val,
  input  logic [1:0]       op_val,
  output logic [VAL_W-1:0] disp_val,
  output logic             disp_neg,
  output logic             err,
  output logic             result_valid,
  output logic [2:0]       state_o
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned Lim  = 10 ** MAX_DIGITS - 1;
  localparam int unsigned SW   = VAL_W + 2;

  typedef enum logic [2:0] {
    StA   = 3'd0,
    StOp  = 3'd1,
    StB   = 3'd2,
    StRes = 3'd3,
    StErr = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [VAL_W-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic              a_neg_q, a_neg_d;
  logic [CntW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic              op_sub_q, op_sub_d;
  logic [VAL_W-1:0]  disp_val_q, disp_val_d;
  logic              disp_neg_q, disp_neg_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;

  // Key classification: eq > op > number; invalid op codes drop the key.
  logic key_eq, key_op, key_num;
  assign key_eq  = key_valid & is_eq;
  assign key_op  = key_valid & ~is_eq & is_op & ((op_val == 2'd1) | (op_val == 2'd2));
  assign key_num = key_valid & ~is_eq & ~is_op & is_number;

  logic [VAL_W-1:0] acc_a_next, acc_b_next, digit_ext;
  assign digit_ext  = VAL_W'(num_val);
  // Only evaluated while cnt < MAX_DIGITS, so the product never exceeds LIM.
  assign acc_a_next = acc_a_q * VAL_W'(10) + digit_ext;
  assign acc_b_next = acc_b_q * VAL_W'(10) + digit_ext;

  logic signed [SW-1:0] a_s, b_s, r_s;
  logic        [SW-1:0] r_mag;
  logic                 r_ovf;
  always_comb begin
    a_s   = signed'({2'b00, acc_a_q});
    if (a_neg_q) a_s = -a_s;
    b_s   = signed'({2'b00, acc_b_q});
    r_s   = op_sub_q ? (a_s - b_s) : (a_s + b_s);
    r_mag = r_s[SW-1] ? unsigned'(-r_s) : unsigned'(r_s);
    r_ovf = r_mag > SW'(Lim);
  end

  always_comb begin
    state_d    = state_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    a_neg_d    = a_neg_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    op_sub_d   = op_sub_q;
    disp_val_d = disp_val_q;
    disp_neg_d = disp_neg_q;
    err_d      = err_q;
    rv_d       = 1'b0;

    case (state_q)
      StA: begin
        if (key_op) begin
          op_sub_d = (op_val == 2'd2);
          state_d  = StOp;
        end else if (key_num && (cnt_a_q < CntW'(MAX_DIGITS))) begin
          acc_a_d    = acc_a_next;
          cnt_a_d    = cnt_a_q + CntW'(1);
          disp_val_d = acc_a_next;
          disp_neg_d = a_neg_q;
        end
      end
      StOp: begin
        if (key_op) begin
          op_sub_d = (op_val == 2'd2);
        end else if (key_num) begin
          acc_b_d    = digit_ext;
          cnt_b_d    = CntW'(1);
          disp_val_d = digit_ext;
          disp_neg_d = 1'b0;
          state_d    = StB;
        end
      end
      StB: begin
        if (key_eq) begin
          if (r_ovf) begin
            err_d      = 1'b1;
            disp_val_d = '0;
            disp_neg_d = 1'b0;
            state_d    = StErr;
          end else begin
            disp_val_d = r_mag[VAL_W-1:0];
            disp_neg_d = r_s[SW-1];
            acc_a_d    = r_mag[VAL_W-1:0];
            a_neg_d    = r_s[SW-1];
            rv_d       = 1'b1;
            state_d    = StRes;
          end
        end else if (key_num && (cnt_b_q < CntW'(MAX_DIGITS))) begin
          acc_b_d    = acc_b_next;
          cnt_b_d    = cnt_b_q + CntW'(1);
          disp_val_d = acc_b_next;
          disp_neg_d = 1'b0;
        end
      end
      StRes, StErr: begin
        // A result may be chained as operand A; an error only leaves on a digit.
        if (key_op && (state_q == StRes)) begin
          op_sub_d = (op_val == 2'd2);
          state_d  = StOp;
        end else if (key_num) begin
          acc_a_d    = digit_ext;
          a_neg_d    = 1'b0;
          cnt_a_d    = CntW'(1);
          disp_val_d = digit_ext;
          disp_neg_d = 1'b0;
          err_d      = 1'b0;
          state_d    = StA;
        end
      end
      default: state_d = StA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StA;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      a_neg_q    <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      op_sub_q   <= 1'b0;
      disp_val_q <= '0;
      disp_neg_q <= 1'b0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      a_neg_q    <= a_neg_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      op_sub_q   <= op_sub_d;
      disp_val_q <= disp_val_d;
      disp_neg_q <= disp_neg_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
    end
  end

  assign disp_val     = disp_val_q;
  assign disp_neg     = disp_neg_q;
  assign err          = err_q;
  assign result_valid = rv_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: a behavioural calculator model predicts the
// display after every cycle; a monitor compares outputs and result pulses.
module tb_calc_ctrl;

  localparam int unsigned VW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_valid = 1'b0, is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
  logic [3:0]    num_val = '0;
  logic [1:0]    op_val = '0;
  logic [VW-1:0] disp_val;
  logic          disp_neg, err, result_valid;
  logic [2:0]    state_o;

  calc_ctrl #(.MAX_DIGITS(4), .VAL_W(VW)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .is_number(is_number), .is_op(is_op),
    .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .disp_val(disp_val),
    .disp_neg(disp_neg), .err(err), .result_valid(result_valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int dv; bit dn; bit er; bit rv; int st;} exp_t;
  typedef struct {int dv; bit dn;} res_t;
  exp_t exp_q[$];
  res_t res_q[$];
  int total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: calculator mode (0 entering A, 1 op chosen, 2 entering B, 3 result, 4 error),
  // signed operand A, operand B, digit counts, and the signed displayed value.
  int m_mode, m_a, m_b, m_cna, m_cnb, m_disp;
  bit m_sub, m_err, m_rv;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(bit r, bit kv, bit nb, bit op, bit eq, int n, int o);
    int res;
    m_rv = 0;
    if (r) begin
      m_mode = 0; m_a = 0; m_b = 0; m_cna = 0; m_cnb = 0;
      m_disp = 0; m_sub = 0; m_err = 0;
    end else if (kv) begin
      if (eq) begin
        if (m_mode == 2) begin
          res = m_sub ? m_a - m_b : m_a + m_b;
          if (iabs(res) > 9999) begin
            m_mode = 4; m_err = 1; m_disp = 0;
          end else begin
            m_mode = 3; m_a = res; m_disp = res; m_rv = 1;
            res_q.push_back('{iabs(res), res < 0});
          end
        end
      end else if (op) begin
        if ((o == 1 || o == 2) && m_mode != 2 && m_mode != 4) begin
          m_sub = (o == 2); m_mode = 1;
        end
      end else if (nb) begin
        case (m_mode)
          0: if (m_cna < 4) begin m_a = m_a * 10 + n; m_cna++; m_disp = m_a; end
          1: begin m_b = n; m_cnb = 1; m_mode = 2; m_disp = n; end
          2: if (m_cnb < 4) begin m_b = m_b * 10 + n; m_cnb++; m_disp = m_b; end
          default: begin m_a = n; m_cna = 1; m_err = 0; m_mode = 0; m_disp = n; end
        endcase
      end
    end
  endtask

  task automatic apply(bit r, bit kv, bit nb, bit op, bit eq, int n, int o);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; key_valid = kv; is_number = nb; is_op = op; is_eq = eq;
    num_val = 4'(n); op_val = 2'(o);
    model(r, kv, nb, op, eq, n, o);
    e.due = cyc + 1; e.dv = iabs(m_disp); e.dn = (m_disp < 0); e.er = m_err;
    e.rv = m_rv; e.st = m_mode;
    exp_q.push_back(e);
  endtask

  task automatic dig(int n);     apply(0, 1, 1, 0, 0, n, 0); endtask
  task automatic opk(int o);     apply(0, 1, 0, 1, 0, 0, o); endtask
  task automatic eqk();          apply(0, 1, 0, 0, 1, 0, 0); endtask
  task automatic idle();         apply(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_rst();       apply(1, 0, 0, 0, 0, 0, 0); endtask

  exp_t ce;
  res_t cr;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      ce = exp_q.pop_front();
      total++; bad++;
      $display("FAIL missed_check due=%0d now=%0d", ce.due, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ce = exp_q.pop_front();
      total++;
      if (disp_val != VW'(ce.dv) || disp_neg != ce.dn || err != ce.er ||
          result_valid != ce.rv || state_o != 3'(ce.st)) begin
        bad++;
        $display("FAIL cycle%0d got val=%0d neg=%0b err=%0b rv=%0b st=%0d want val=%0d neg=%0b err=%0b rv=%0b st=%0d",
                 cyc, disp_val, disp_neg, err, result_valid, state_o,
                 ce.dv, ce.dn, ce.er, ce.rv, ce.st);
      end
    end
    if (result_valid) begin
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got val=%0d neg=%0b want no pulse", disp_val, disp_neg);
      end else begin
        cr = res_q.pop_front();
        if (disp_val != VW'(cr.dv) || disp_neg != cr.dn) begin
          bad++;
          $display("FAIL result got val=%0d neg=%0b want val=%0d neg=%0b",
                   disp_val, disp_neg, cr.dv, cr.dn);
        end
      end
    end
  end

  initial begin
    int k, n, o;
    bit nb, op, eq;
    do_rst(); do_rst();
    // 1: 12 + 34 = 46
    dig(1); dig(2); opk(1); dig(3); dig(4); eqk(); idle(); idle();
    // 2: 5 - 12 = -7, then chain + 20 = 13
    dig(5); opk(2); dig(1); dig(2); eqk(); opk(1); dig(2); dig(0); eqk(); idle();
    // 3: digit limit, overflow, recovery
    for (int i = 0; i < 5; i++) dig(9);
    opk(1); dig(1); eqk(); opk(1); eqk(); dig(3); idle();
    // 4: zero result, operator replaced in op state
    do_rst(); dig(5); opk(2); dig(5); eqk(); opk(1); opk(2); dig(2); eqk(); idle();
    // 5: ignored keys, reset together with a key
    apply(0, 0, 1, 0, 0, 7, 0); opk(3); opk(0); apply(0, 1, 0, 0, 0, 4, 1);
    dig(4); dig(6); apply(1, 1, 1, 0, 0, 8, 0); idle();
    // 6: fresh digit after result; eq in A and op states ignored
    dig(1); opk(1); dig(1); eqk(); dig(7); eqk(); opk(1); eqk(); idle();
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 99);
      n = $urandom_range(0, 9);
      o = $urandom_range(0, 3);
      if (k < 2) apply(1, $urandom_range(0, 1), 1, 0, 0, n, o);
      else if (k < 8) apply(0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                            $urandom_range(0, 1), n, o);
      else if (k < 60) dig(n);
      else if (k < 74) opk((o == 0 || o == 3) && k < 70 ? 1 : o);
      else if (k < 88) eqk();
      else if (k < 95) begin
        nb = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
        eq = 1'($urandom_range(0, 1));
        apply(0, 1, nb, op, eq, n, o);
      end else idle();
    end
    idle(); idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending_cycles=%0d pending_results=%0d want 0 and 0",
               exp_q.size(), res_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
